// File: rtl/elevator_sequencer_pkg.sv
// Shared constants, state encoding and floor-mask helpers for the elevator sequencer.
package elevator_pkg;

    localparam int NFLOOR = 4;
    localparam int FW     = 2;
    localparam int GAP    = 8;
    localparam int GCW    = $clog2(GAP);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        OPEN    = 2'd2,
        GAPWAIT = 2'd3
    } state_t;

    // One-hot bit for a single floor index.
    function automatic logic [NFLOOR-1:0] floor_bit(input logic [FW-1:0] f);
        logic [NFLOOR-1:0] m;
        m = '0;
        for (int i = 0; i < NFLOOR; i++) begin
            m[i] = (i == int'(f));
        end
        return m;
    endfunction

    // Bits of every floor strictly above f.
    function automatic logic [NFLOOR-1:0] above_mask(input logic [FW-1:0] f);
        logic [NFLOOR-1:0] m;
        m = '0;
        for (int i = 0; i < NFLOOR; i++) begin
            m[i] = (i > int'(f));
        end
        return m;
    endfunction

    // Bits of every floor strictly below f.
    function automatic logic [NFLOOR-1:0] below_mask(input logic [FW-1:0] f);
        logic [NFLOOR-1:0] m;
        m = '0;
        for (int i = 0; i < NFLOOR; i++) begin
            m[i] = (i < int'(f));
        end
        return m;
    endfunction

endpackage

// File: rtl/elevator_sequencer_if.sv
// Request/timer handshake and status bundle between the sequencer and its surroundings.
interface elevator_sequencer_if;
    import elevator_pkg::*;

    logic [NFLOOR-1:0] req;
    logic              endRun;
    logic              endOpen;
    logic              mv2nxt;
    logic              opendoor;
    logic [FW-1:0]     floor;
    logic              dir_up;
    logic [NFLOOR-1:0] pending;
    logic              busy;

    // The sequencer itself drives commands and status.
    modport master (
        input  req, endRun, endOpen,
        output mv2nxt, opendoor, floor, dir_up, pending, busy
    );

    // Request sources and timers drive requests and completions.
    modport slave (
        output req, endRun, endOpen,
        input  mv2nxt, opendoor, floor, dir_up, pending, busy
    );

endinterface

// File: rtl/elevator_sequencer_req_register.sv
// Outstanding-request bits: per-bit set, single indexed clear, clear beats set on the same bit.
module req_register
    import elevator_pkg::*;
(
    input  logic              CP,
    input  logic              rst,
    input  logic [NFLOOR-1:0] set_mask,
    input  logic              clr_en,
    input  logic [FW-1:0]     clr_idx,
    output logic [NFLOOR-1:0] pending
);

    logic [NFLOOR-1:0] clr_mask;

    // Decode the floor being opened into the bit that must drop.
    always_comb begin
        clr_mask = clr_en ? floor_bit(clr_idx) : '0;
    end

    // Accumulate new requests, then apply the clear so it wins a collision.
    always_ff @(posedge CP) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending | set_mask) & ~clr_mask;
        end
    end

endmodule

// File: rtl/elevator_sequencer.sv
// Master control FSM for the car: latches requests, picks direction (SCAN), drives run/open timers.
module elevator_sequencer
    import elevator_pkg::*;
(
    input  logic CP,
    input  logic rst,
    elevator_sequencer_if.master bus
);

    localparam logic [FW-1:0] FLOOR_MAX = FW'(NFLOOR - 1);

    state_t            state, state_n;
    logic [FW-1:0]     floor_q, floor_n, step_floor;
    logic              dir_up_q, dir_up_n;
    logic              mv2nxt_q, mv2nxt_n;
    logic              opendoor_q, opendoor_n;
    logic [GCW-1:0]    gap_cnt, gap_cnt_n;
    logic              armed_run, armed_run_n;
    logic              armed_open, armed_open_n;
    logic              clr_en;
    logic [FW-1:0]     clr_idx;
    logic [NFLOOR-1:0] pending, set_mask, above, below;

    req_register u_req (
        .CP       (CP),
        .rst      (rst),
        .set_mask (set_mask),
        .clr_en   (clr_en),
        .clr_idx  (clr_idx),
        .pending  (pending)
    );

    // Request filtering: with the door open, a call for this floor is already served.
    always_comb begin
        set_mask = bus.req;
        if (state == OPEN) begin
            set_mask = bus.req & ~floor_bit(floor_q);
        end
        above = pending & above_mask(floor_q);
        below = pending & below_mask(floor_q);
    end

    // Neighbour floor in the travel direction, pinned at the shaft ends.
    always_comb begin
        step_floor = floor_q;
        if (dir_up_q) begin
            if (floor_q != FLOOR_MAX) begin
                step_floor = floor_q + 1'b1;
            end
        end else if (floor_q != '0) begin
            step_floor = floor_q - 1'b1;
        end
    end

    // Next-state and command logic; timer completions count only after being seen low.
    always_comb begin
        state_n      = state;
        floor_n      = floor_q;
        dir_up_n     = dir_up_q;
        mv2nxt_n     = mv2nxt_q;
        opendoor_n   = opendoor_q;
        gap_cnt_n    = gap_cnt;
        armed_run_n  = armed_run;
        armed_open_n = armed_open;
        clr_en       = 1'b0;
        clr_idx      = floor_q;
        unique case (state)
            IDLE: begin
                if (pending[floor_q]) begin
                    state_n      = OPEN;
                    opendoor_n   = 1'b1;
                    armed_open_n = 1'b0;
                    clr_en       = 1'b1;
                end else if (dir_up_q && (|above)) begin
                    state_n     = RUN;
                    armed_run_n = 1'b0;
                end else if (|below) begin
                    state_n     = RUN;
                    dir_up_n    = 1'b0;
                    armed_run_n = 1'b0;
                end else if (|above) begin
                    state_n     = RUN;
                    dir_up_n    = 1'b1;
                    armed_run_n = 1'b0;
                end
            end
            RUN: begin
                if (bus.endRun && armed_run) begin
                    floor_n     = step_floor;
                    mv2nxt_n    = 1'b0;
                    armed_run_n = 1'b0;
                    if (pending[step_floor]) begin
                        state_n      = OPEN;
                        opendoor_n   = 1'b1;
                        armed_open_n = 1'b0;
                        clr_en       = 1'b1;
                        clr_idx      = step_floor;
                    end else begin
                        state_n   = GAPWAIT;
                        gap_cnt_n = '0;
                    end
                end else begin
                    mv2nxt_n    = 1'b1;
                    armed_run_n = armed_run | ~bus.endRun;
                end
            end
            OPEN: begin
                if (bus.endOpen && armed_open) begin
                    opendoor_n   = 1'b0;
                    armed_open_n = 1'b0;
                    state_n      = GAPWAIT;
                    gap_cnt_n    = '0;
                end else begin
                    armed_open_n = armed_open | ~bus.endOpen;
                end
            end
            GAPWAIT: begin
                if (gap_cnt == GCW'(GAP - 1)) begin
                    state_n   = IDLE;
                    gap_cnt_n = '0;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CP) begin
        if (rst) begin
            state      <= IDLE;
            floor_q    <= '0;
            dir_up_q   <= 1'b1;
            mv2nxt_q   <= 1'b0;
            opendoor_q <= 1'b0;
            gap_cnt    <= '0;
            armed_run  <= 1'b0;
            armed_open <= 1'b0;
        end else begin
            state      <= state_n;
            floor_q    <= floor_n;
            dir_up_q   <= dir_up_n;
            mv2nxt_q   <= mv2nxt_n;
            opendoor_q <= opendoor_n;
            gap_cnt    <= gap_cnt_n;
            armed_run  <= armed_run_n;
            armed_open <= armed_open_n;
        end
    end

    assign bus.mv2nxt   = mv2nxt_q;
    assign bus.opendoor = opendoor_q;
    assign bus.floor    = floor_q;
    assign bus.dir_up   = dir_up_q;
    assign bus.pending  = pending;
    assign bus.busy     = (state != IDLE);

    // Moving and opening must never be commanded together.
    a_cmd_excl: assert property (@(posedge CP) disable iff (rst) !(mv2nxt_q && opendoor_q));

endmodule

// File: tb/tb_elevator_sequencer.sv
// Self-checking bench: procedural reference model of the car plus directed and random stimulus.
module tb_elevator_sequencer;
    import elevator_pkg::*;

    logic CP;
    logic rst;
    elevator_sequencer_if bus ();

    elevator_sequencer dut (
        .CP  (CP),
        .rst (rst),
        .bus (bus)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    int n_compared;
    int n_mismatched;
    bit chk_on;

    // Reference model state.
    int         m_floor;
    bit         m_up, m_mv, m_door, m_busy;
    logic [3:0] m_pend, p_old, s_req;
    bit         s_rst, s_er, s_eo;

    // Timer model and trackers.
    int  run_age, run_left, run_delay, run_hold;
    int  open_age, open_left, open_delay, open_hold;
    bit  auto_run, auto_open, rand_tmr, track_age;
    int  open_cnt [NFLOOR];
    int  open_q [$];
    int  step_cnt, mv_rise_cnt, max_age;
    int  age [NFLOOR];
    bit  prev_door, prev_mv;
    logic [FW-1:0] prev_floor;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_clear();
        m_floor = 0; m_up = 1'b1; m_mv = 1'b0; m_door = 1'b0; m_busy = 1'b0; m_pend = '0;
    endtask

    // One clock of the car: sample inputs, latch calls (door-open floor excluded).
    task automatic m_step(input bit door_open, output bit aborted);
        @(posedge CP);
        s_rst = rst; s_req = bus.req; s_er = bus.endRun; s_eo = bus.endOpen;
        p_old = m_pend;
        for (int i = 0; i < NFLOOR; i++) begin
            if (s_req[i] && !(door_open && i == m_floor)) m_pend[i] = 1'b1;
        end
        aborted = s_rst;
        if (s_rst) m_clear();
    endtask

    task automatic m_gap(output bit aborted);
        for (int k = 0; k < GAP; k++) begin
            m_step(1'b0, aborted);
            if (aborted) return;
        end
        m_busy = 1'b0;
    endtask

    task automatic m_open(output bit aborted);
        bit armed = 1'b0;
        forever begin
            m_step(1'b1, aborted);
            if (aborted) return;
            if (s_eo && armed) begin
                m_door = 1'b0;
                m_gap(aborted);
                return;
            end
            armed = armed | !s_eo;
        end
    endtask

    task automatic m_run(output bit aborted);
        bit armed = 1'b0;
        forever begin
            m_step(1'b0, aborted);
            if (aborted) return;
            if (s_er && armed) begin
                m_floor = m_floor + (m_up ? 1 : -1);
                m_mv = 1'b0;
                if (p_old[m_floor]) begin
                    m_pend[m_floor] = 1'b0;
                    m_door = 1'b1;
                    m_open(aborted);
                end else begin
                    m_gap(aborted);
                end
                return;
            end
            m_mv = 1'b1;
            armed = armed | !s_er;
        end
    endtask

    // SCAN decision each idle clock, from the call list as it stood before this clock.
    initial begin : ref_model
        bit ab;
        bit any_above, any_below;
        m_clear();
        forever begin
            m_step(1'b0, ab);
            if (!ab) begin
                any_above = 1'b0;
                any_below = 1'b0;
                for (int i = 0; i < NFLOOR; i++) begin
                    if (p_old[i] && i > m_floor) any_above = 1'b1;
                    if (p_old[i] && i < m_floor) any_below = 1'b1;
                end
                if (p_old[m_floor]) begin
                    m_pend[m_floor] = 1'b0; m_door = 1'b1; m_busy = 1'b1; m_open(ab);
                end else if (m_up && any_above) begin
                    m_busy = 1'b1; m_run(ab);
                end else if (any_below) begin
                    m_up = 1'b0; m_busy = 1'b1; m_run(ab);
                end else if (any_above) begin
                    m_up = 1'b1; m_busy = 1'b1; m_run(ab);
                end
            end
        end
    end

    task automatic timers();
        if (auto_run) begin
            if (bus.mv2nxt) run_age++; else run_age = 0;
            if (run_left > 0) run_left--;
            if (rand_tmr && run_age == 1) begin
                run_delay = $urandom_range(2, 30);
                run_hold  = $urandom_range(1, GAP);
            end
            if (run_age == run_delay) run_left = run_hold;
            bus.endRun = (run_left > 0);
        end
        if (auto_open) begin
            if (bus.opendoor) open_age++; else open_age = 0;
            if (open_left > 0) open_left--;
            if (rand_tmr && open_age == 1) begin
                open_delay = $urandom_range(2, 30);
                open_hold  = $urandom_range(1, GAP);
            end
            if (open_age == open_delay) open_left = open_hold;
            bus.endOpen = (open_left > 0);
        end
    endtask

    // Advance one clock, compare against the model, record events, then drive timers.
    task automatic applyStimulus();
        @(negedge CP);
        if (chk_on) begin
            checkOutput("floor", 32'(bus.floor), 32'(m_floor));
            checkOutput("dir_up", 32'(bus.dir_up), 32'(m_up));
            checkOutput("mv2nxt", 32'(bus.mv2nxt), 32'(m_mv));
            checkOutput("opendoor", 32'(bus.opendoor), 32'(m_door));
            checkOutput("pending", 32'(bus.pending), 32'(m_pend));
            checkOutput("busy", 32'(bus.busy), 32'(m_busy));
            checkOutput("cmd_excl", 32'(bus.mv2nxt & bus.opendoor), 32'd0);
        end
        if (bus.opendoor && !prev_door) begin
            open_cnt[bus.floor]++;
            open_q.push_back(int'(bus.floor));
        end
        if (bus.mv2nxt && !prev_mv) mv_rise_cnt++;
        if (bus.floor != prev_floor) step_cnt++;
        prev_door  = bus.opendoor;
        prev_mv    = bus.mv2nxt;
        prev_floor = bus.floor;
        if (track_age) begin
            for (int i = 0; i < NFLOOR; i++) begin
                if (bus.pending[i]) age[i]++; else age[i] = 0;
                if (age[i] > max_age) max_age = age[i];
            end
        end
        timers();
    endtask

    task automatic clearTrack();
        for (int i = 0; i < NFLOOR; i++) open_cnt[i] = 0;
        open_q.delete();
        step_cnt = 0;
        mv_rise_cnt = 0;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
    endtask

    task automatic pulseReq(input logic [3:0] r);
        bus.req = r;
        applyStimulus();
        bus.req = '0;
    endtask

    task automatic waitDoor(input string tag, input int budget);
        int k = 0;
        while (!bus.opendoor && k < budget) begin
            applyStimulus();
            k++;
        end
        checkOutput(tag, 32'(bus.opendoor), 32'd1);
    endtask

    initial begin
        n_compared = 0; n_mismatched = 0; chk_on = 1'b0;
        bus.req = '0; bus.endRun = 1'b0; bus.endOpen = 1'b0; rst = 1'b0;
        auto_run = 1'b1; auto_open = 1'b1; rand_tmr = 1'b0; track_age = 1'b0;
        run_age = 0; run_left = 0; run_delay = 48; run_hold = GAP;
        open_age = 0; open_left = 0; open_delay = 3; open_hold = GAP;
        max_age = 0; prev_door = 1'b0; prev_mv = 1'b0; prev_floor = '0;
        for (int i = 0; i < NFLOOR; i++) age[i] = 0;
        clearTrack();
        repeat (2) @(negedge CP);

        // Reset values and an immediate call at the resting floor.
        chk_on = 1'b1;
        applyReset();
        checkOutput("rst_floor", 32'(bus.floor), 32'd0);
        checkOutput("rst_dir", 32'(bus.dir_up), 32'd1);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_pend", 32'(bus.pending), 32'd0);
        pulseReq(4'b0001);
        checkOutput("t1_latched", 32'(bus.pending), 32'h1);
        checkOutput("t1_door_early", 32'(bus.opendoor), 32'd0);
        applyStimulus();
        checkOutput("t1_door", 32'(bus.opendoor), 32'd1);
        checkOutput("t1_pend_clr", 32'(bus.pending), 32'd0);
        repeat (20) applyStimulus();
        checkOutput("t1_idle", 32'(bus.busy), 32'd0);

        // Three single-floor runs to the top with a slow run timer.
        clearTrack();
        pulseReq(4'b1000);
        repeat (400) applyStimulus();
        checkOutput("t2_floor", 32'(bus.floor), 32'd3);
        checkOutput("t2_steps", 32'(step_cnt), 32'd3);
        checkOutput("t2_runs", 32'(mv_rise_cnt), 32'd3);
        checkOutput("t2_open1", 32'(open_cnt[1]), 32'd0);
        checkOutput("t2_open2", 32'(open_cnt[2]), 32'd0);
        checkOutput("t2_open3", 32'(open_cnt[3]), 32'd1);

        // Up to the top first, then reverse down to the ground floor.
        run_delay = 6; open_delay = 4;
        applyReset();
        clearTrack();
        pulseReq(4'b0100);
        waitDoor("t3_door2", 200);
        checkOutput("t3_at2", 32'(bus.floor), 32'd2);
        pulseReq(4'b1001);
        repeat (600) applyStimulus();
        checkOutput("t3_nopens", 32'(open_q.size()), 32'd3);
        if (open_q.size() == 3) begin
            checkOutput("t3_first", 32'(open_q[0]), 32'd2);
            checkOutput("t3_second", 32'(open_q[1]), 32'd3);
            checkOutput("t3_third", 32'(open_q[2]), 32'd0);
        end
        checkOutput("t3_dir", 32'(bus.dir_up), 32'd0);

        // Calls during an open door: own floor ignored, other floor kept.
        clearTrack();
        pulseReq(4'b0001);
        waitDoor("t4_door0", 10);
        pulseReq(4'b0001);
        pulseReq(4'b0010);
        checkOutput("t4_pend", 32'(bus.pending), 32'h2);
        repeat (300) applyStimulus();
        checkOutput("t4_open0", 32'(open_cnt[0]), 32'd1);
        checkOutput("t4_open1", 32'(open_cnt[1]), 32'd1);
        checkOutput("t4_floor", 32'(bus.floor), 32'd1);

        // Reset in the middle of a run.
        run_delay = 48;
        pulseReq(4'b1000);
        for (int k = 0; k < 50 && !bus.mv2nxt; k++) applyStimulus();
        checkOutput("t5_moving", 32'(bus.mv2nxt), 32'd1);
        checkOutput("t5_from1", 32'(bus.floor), 32'd1);
        applyReset();
        checkOutput("t5_floor", 32'(bus.floor), 32'd0);
        checkOutput("t5_mv", 32'(bus.mv2nxt), 32'd0);
        checkOutput("t5_pend", 32'(bus.pending), 32'd0);
        checkOutput("t5_busy", 32'(bus.busy), 32'd0);

        // A completion already high at run start is a stale tail and must not step.
        auto_run = 1'b0;
        bus.endRun = 1'b1;
        pulseReq(4'b0010);
        repeat (30) applyStimulus();
        checkOutput("t6_stuck", 32'(bus.floor), 32'd0);
        checkOutput("t6_mv", 32'(bus.mv2nxt), 32'd1);
        bus.endRun = 1'b0;
        applyStimulus();
        bus.endRun = 1'b1;
        applyStimulus();
        checkOutput("t6_step", 32'(bus.floor), 32'd1);
        checkOutput("t6_door", 32'(bus.opendoor), 32'd1);
        repeat (5) applyStimulus();
        bus.endRun = 1'b0;
        repeat (40) applyStimulus();
        checkOutput("t6_once", 32'(bus.floor), 32'd1);
        checkOutput("t6_idle", 32'(bus.busy), 32'd0);
        run_age = 0; run_left = 0;
        auto_run = 1'b1;

        // Random call bursts with randomized timer latencies.
        rand_tmr = 1'b1;
        track_age = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            bus.req = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            rst = ($urandom_range(0, 4999) == 0);
            applyStimulus();
        end
        bus.req = '0;
        rst = 1'b0;
        repeat (1500) applyStimulus();
        checkOutput("rnd_drained", 32'(bus.pending), 32'd0);
        checkOutput("rnd_idle", 32'(bus.busy), 32'd0);
        checkOutput("rnd_age_ok", 32'(max_age < 1500), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
